// File: rtl/aes_pkg.sv
// Shared AES-128 definitions for the inverse key scheduler.
//  - AES_ROUNDS : number of AES-128 rounds
//  - state_e    : scheduler FSM states
//  - rcon()     : round constant for round index 1..10 (00 elsewhere)
//  - key_word() : 32-bit word slice of a 128-bit key, word0 = [127:96]
//  - rot_word() : AES RotWord
//  - sbox_fn()  : AES S-box computed as GF(2^8) inverse followed by the affine map
package aes_pkg;

    localparam int AES_ROUNDS = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FWD  = 2'd1,
        EMIT = 2'd2,
        DONE = 2'd3
    } state_e;

    function automatic logic [7:0] rcon(input logic [3:0] r);
        logic [7:0] rc;
        case (r)
            4'd1:    rc = 8'h01;
            4'd2:    rc = 8'h02;
            4'd3:    rc = 8'h04;
            4'd4:    rc = 8'h08;
            4'd5:    rc = 8'h10;
            4'd6:    rc = 8'h20;
            4'd7:    rc = 8'h40;
            4'd8:    rc = 8'h80;
            4'd9:    rc = 8'h1b;
            4'd10:   rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

    function automatic logic [31:0] key_word(input logic [127:0] k, input int idx);
        return k[127-32*idx -: 32];
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    // Multiplication in GF(2^8) modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Inverse is b^254 (b^2 * b^4 * ... * b^128); 0 maps to 0 naturally.
    function automatic logic [7:0] sbox_fn(input logic [7:0] b);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = b;
        inv = 8'h01;
        for (int i = 0; i < 7; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

endpackage

// File: rtl/aes_inv_key_step.sv
// One inverse AES-128 key-expansion step: round-r key -> round-(r-1) key.
//  key_i   : round-r key, word0 = [127:96]
//  round_i : r (1..10), selects the round constant
//  key_o   : round-(r-1) key
module aes_inv_key_step
    import aes_pkg::*;
(
    input  logic [127:0] key_i,
    input  logic [3:0]   round_i,
    output logic [127:0] key_o
);

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] w0p, w1p, w2p, w3p;
    logic [31:0] rot_w;
    logic [31:0] sub_w;

    assign w0 = key_word(key_i, 0);
    assign w1 = key_word(key_i, 1);
    assign w2 = key_word(key_i, 2);
    assign w3 = key_word(key_i, 3);

    // Words 1..3 are recovered by undoing the forward XOR chain.
    assign w3p = w3 ^ w2;
    assign w2p = w2 ^ w1;
    assign w1p = w1 ^ w0;

    // Word 0 needs the previous key's word 3 (w3p) through SubWord(RotWord()).
    assign rot_w = rot_word(w3p);

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_sbox
            aes_sbox u_sbox (
                .byte_i (rot_w[8*gi +: 8]),
                .byte_o (sub_w[8*gi +: 8])
            );
        end
    endgenerate

    assign w0p   = w0 ^ sub_w ^ {rcon(round_i), 24'h0};
    assign key_o = {w0p, w1p, w2p, w3p};

endmodule

// File: rtl/aes_sbox.sv
// AES S-box, purely combinational.
//  byte_i : input byte
//  byte_o : substituted byte
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] byte_i,
    output logic [7:0] byte_o
);

    assign byte_o = sbox_fn(byte_i);

endmodule

// File: rtl/aes_inv_key_sched.sv
// AES-128 decryption key scheduler. Expands the cipher key forward to the
// round-10 key, then emits round keys 10 down to 0 over a valid/ready handshake.
//  clk      : clock, rising edge
//  reset    : asynchronous active-high reset
//  start    : load key_in and begin (only honoured in IDLE)
//  key_in   : cipher key (round-0 key)
//  busy     : high in every state except IDLE
//  rk_valid : rk_out/rk_round valid
//  rk_ready : consumer accepts the current round key
//  rk_out   : current round key
//  rk_round : round index of rk_out
//  done     : one-cycle pulse after the round-0 key is accepted
module aes_inv_key_sched
    import aes_pkg::*;
#(
    parameter int KEY_W  = 128,
    parameter int ROUNDS = AES_ROUNDS
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [KEY_W-1:0] key_in,
    output logic             busy,
    output logic             rk_valid,
    input  logic             rk_ready,
    output logic [KEY_W-1:0] rk_out,
    output logic [3:0]       rk_round,
    output logic             done
);

    localparam logic [3:0] LAST_ROUND = 4'(ROUNDS);

    state_e           state_q;
    logic [KEY_W-1:0] key_q;
    logic [3:0]       cnt_q;

    logic [3:0]       cnt_inc;
    logic [31:0]      fwd_rot;
    logic [31:0]      fwd_sub;
    logic [31:0]      fwd_t;
    logic [31:0]      fw0, fw1, fw2, fw3;
    logic [KEY_W-1:0] fwd_key_d;
    logic [KEY_W-1:0] inv_key_d;

    // Forward expansion step: key_q holds round cnt_q, produce round cnt_q+1.
    assign cnt_inc = cnt_q + 4'd1;
    assign fwd_rot = rot_word(key_word(key_q, 3));

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_fwd_sbox
            aes_sbox u_sbox (
                .byte_i (fwd_rot[8*gi +: 8]),
                .byte_o (fwd_sub[8*gi +: 8])
            );
        end
    endgenerate

    assign fwd_t     = fwd_sub ^ {rcon(cnt_inc), 24'h0};
    assign fw0       = key_word(key_q, 0) ^ fwd_t;
    assign fw1       = key_word(key_q, 1) ^ fw0;
    assign fw2       = key_word(key_q, 2) ^ fw1;
    assign fw3       = key_word(key_q, 3) ^ fw2;
    assign fwd_key_d = {fw0, fw1, fw2, fw3};

    aes_inv_key_step u_inv_step (
        .key_i   (key_q),
        .round_i (cnt_q),
        .key_o   (inv_key_d)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            key_q   <= '0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        key_q   <= key_in;
                        cnt_q   <= 4'd0;
                        state_q <= FWD;
                    end
                end
                FWD: begin
                    key_q <= fwd_key_d;
                    cnt_q <= cnt_inc;
                    if (cnt_inc == LAST_ROUND) state_q <= EMIT;
                end
                EMIT: begin
                    // Without rk_ready nothing moves, so rk_out/rk_round stay put.
                    if (rk_ready) begin
                        if (cnt_q != 4'd0) begin
                            key_q <= inv_key_d;
                            cnt_q <= cnt_q - 4'd1;
                        end else begin
                            state_q <= DONE;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Outputs decode registered state only; rk_valid never looks at rk_ready.
    assign busy     = (state_q != IDLE);
    assign rk_valid = (state_q == EMIT);
    assign rk_out   = rk_valid ? key_q : '0;
    assign rk_round = rk_valid ? cnt_q : 4'd0;
    assign done     = (state_q == DONE);

endmodule

// File: tb/tb_aes_inv_key_sched.sv
module tb_aes_inv_key_sched;

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] FIPS_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] ZERO_R10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [127:0] key_in;
    logic         busy;
    logic         rk_valid;
    logic         rk_ready;
    logic [127:0] rk_out;
    logic [3:0]   rk_round;
    logic         done;

    always #5 clk = ~clk;

    aes_inv_key_sched dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .key_in   (key_in),
        .busy     (busy),
        .rk_valid (rk_valid),
        .rk_ready (rk_ready),
        .rk_out   (rk_out),
        .rk_round (rk_round),
        .done     (done)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input bit ok, input string name,
                         input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0]   sb [0:255];
    logic [127:0] exp_rk [0:10];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r = 8'h00;
        logic [7:0] aa = a;
        logic [7:0] bb = b;
        while (bb != 8'h00) begin
            if (bb[0]) r = r ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
            bb = bb >> 1;
        end
        return r;
    endfunction

    // S-box by exhaustive inverse search plus the bitwise affine formula.
    task automatic build_sbox();
        logic [7:0] c = 8'h63;
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h00;
            logic [7:0] s;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            for (int i = 0; i < 8; i++)
                s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
            sb[x] = s;
        end
    endtask

    // Textbook 44-word key expansion; round r key = words 4r..4r+3.
    task automatic model_expand(input logic [127:0] key);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= 10; r++)
            exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // ---------------- consumer ready driver ----------------
    int ready_pct = 100;
    always @(posedge clk) begin
        #1;
        rk_ready = ($urandom_range(0, 99) < ready_pct);
    end

    // ---------------- compare process ----------------
    int           exp_round = -1;
    int           hs_cnt    = 0;
    int           done_cnt  = 0;
    logic [127:0] got_rk [0:10];

    always @(negedge clk) begin
        if (!reset) begin
            if (rk_valid) begin
                check(int'(rk_round) == exp_round, "rk_round", 128'(rk_round), 128'(exp_round));
                if (exp_round >= 0 && exp_round <= 10)
                    check(rk_out == exp_rk[exp_round], "rk_out", rk_out, exp_rk[exp_round]);
                if (rk_ready) begin
                    $display("handshake round=%0d key=%h", rk_round, rk_out);
                    if (rk_round <= 4'd10) got_rk[rk_round] = rk_out;
                    hs_cnt++;
                    exp_round--;
                end
            end
            if (done) done_cnt++;
        end
    end

    // ---------------- sequencing helpers ----------------
    task automatic arm(input logic [127:0] key);
        model_expand(key);
        exp_round = 10;
        hs_cnt    = 0;
        done_cnt  = 0;
    endtask

    // mode 0: drop start; 1: pulse start with a bogus key mid-FWD; 2: keep start as is
    task automatic wait_valid(input int mode, input int exp_lat);
        int  n = 0;
        bit  seen = 0;
        while (!seen && n < 60) begin
            @(posedge clk); #1;
            n++;
            if (mode == 0) start = 1'b0;
            if (mode == 1) begin
                start = (n == 3);
                if (n == 3) key_in = 128'hdeadbeef_01234567_89abcdef_fedcba98;
            end
            @(negedge clk); #1;
            seen = rk_valid;
        end
        start = 1'b0;
        check(n == exp_lat && seen, "latency", 128'(n), 128'(exp_lat));
    endtask

    task automatic launch(input logic [127:0] key, input int mode);
        @(posedge clk); #1;
        key_in = key;
        start  = 1'b1;
        wait_valid(mode, 11);
    endtask

    task automatic finish_run(input bit inject, input bit hold, input logic [127:0] next_key);
        int k = 0;
        while (done_cnt == 0 && k < 1000) begin
            @(posedge clk); #1;
            k++;
            if (inject) start = (k == 2);
            @(negedge clk); #1;
        end
        check(done_cnt == 1, "done_seen", 128'(done_cnt), 128'd1);
        if (hold) begin
            start  = 1'b1;
            key_in = next_key;
        end else begin
            start = 1'b0;
        end
        @(negedge clk); #1;
        check(busy == 1'b0, "busy_after_done", 128'(busy), 128'd0);
        check(done == 1'b0, "done_one_cycle", 128'(done), 128'd0);
        check(done_cnt == 1, "done_count", 128'(done_cnt), 128'd1);
        check(hs_cnt == 11, "handshakes", 128'(hs_cnt), 128'd11);
        check(exp_round == -1, "all_rounds", 128'(exp_round), 128'hffffffff);
    endtask

    task automatic check_zero_outputs(input string tag);
        check(busy == 1'b0,     {tag, "_busy"},     128'(busy),     128'd0);
        check(rk_valid == 1'b0, {tag, "_rk_valid"}, 128'(rk_valid), 128'd0);
        check(rk_out == '0,     {tag, "_rk_out"},   rk_out,         128'd0);
        check(rk_round == 4'd0, {tag, "_rk_round"}, 128'(rk_round), 128'd0);
        check(done == 1'b0,     {tag, "_done"},     128'(done),     128'd0);
    endtask

    task automatic release_and_idle();
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); #1;
        end
        check(done_cnt == 0, "no_done_after_reset", 128'(done_cnt), 128'd0);
        check(busy == 1'b0, "idle_after_reset", 128'(busy), 128'd0);
    endtask

    // ---------------- main ----------------
    initial begin
        reset  = 1'b1;
        start  = 1'b0;
        key_in = '0;
        build_sbox();

        // Pin the model to published vectors.
        model_expand(FIPS_KEY);
        check(exp_rk[10] == FIPS_R10, "model_fips_r10", exp_rk[10], FIPS_R10);
        check(exp_rk[1] == FIPS_R1, "model_fips_r1", exp_rk[1], FIPS_R1);
        model_expand('0);
        check(exp_rk[10] == ZERO_R10, "model_zero_r10", exp_rk[10], ZERO_R10);

        repeat (3) @(negedge clk);
        #1;
        check_zero_outputs("reset");
        @(posedge clk); #1;
        reset = 1'b0;

        // FIPS-197 key, consumer always ready.
        ready_pct = 100;
        arm(FIPS_KEY);
        launch(FIPS_KEY, 0);
        check(rk_round == 4'd10, "fips_first_round", 128'(rk_round), 128'd10);
        check(rk_out == FIPS_R10, "fips_first_key", rk_out, FIPS_R10);
        finish_run(0, 0, '0);
        check(got_rk[1] == FIPS_R1, "fips_r1", got_rk[1], FIPS_R1);
        check(got_rk[0] == FIPS_KEY, "fips_r0", got_rk[0], FIPS_KEY);

        // Random back-pressure.
        ready_pct = 30;
        arm(128'h000102030405060708090a0b0c0d0e0f);
        launch(128'h000102030405060708090a0b0c0d0e0f, 0);
        finish_run(0, 0, '0);
        check(got_rk[0] == 128'h000102030405060708090a0b0c0d0e0f, "bp_r0",
              got_rk[0], 128'h000102030405060708090a0b0c0d0e0f);

        // All-zero key.
        ready_pct = 100;
        arm('0);
        launch('0, 0);
        check(rk_out == ZERO_R10, "zero_first_key", rk_out, ZERO_R10);
        finish_run(0, 0, '0);
        check(got_rk[0] == '0, "zero_r0", got_rk[0], 128'd0);

        // start pulsed in FWD and EMIT, then held through DONE.
        arm(FIPS_KEY);
        launch(FIPS_KEY, 1);
        finish_run(1, 1, 128'hffeeddccbbaa99887766554433221100);
        arm(128'hffeeddccbbaa99887766554433221100);
        wait_valid(2, 11);
        finish_run(0, 0, '0);

        // Reset in FWD with cnt=5.
        arm(FIPS_KEY);
        @(posedge clk); #1;
        key_in = FIPS_KEY;
        start  = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_zero_outputs("rst_fwd");
        release_and_idle();

        // Reset in EMIT while round 4 is presented.
        arm(FIPS_KEY);
        launch(FIPS_KEY, 0);
        begin
            int k = 0;
            while (!(rk_valid && rk_round == 4'd4) && k < 30) begin
                @(negedge clk); #1;
                k++;
            end
            check(rk_round == 4'd4, "reach_round4", 128'(rk_round), 128'd4);
        end
        reset = 1'b1;
        #1;
        check_zero_outputs("rst_emit");
        release_and_idle();

        // Full clean run after the aborted ones.
        ready_pct = 60;
        arm(FIPS_KEY);
        launch(FIPS_KEY, 0);
        finish_run(0, 0, '0);
        check(got_rk[0] == FIPS_KEY, "post_reset_r0", got_rk[0], FIPS_KEY);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
